// File: rtl/systolic_pkg.sv
// Shared defaults and controller state type for the systolic skew feeder.
package systolic_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned N_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Width of a counter indexing n items, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_select.sv
// One edge lane of the skew network: returns buffered element (phase - LANE)
// of its row while streaming, zero outside the diagonal window.
module skew_select
    import systolic_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned N    = N_DEF,
    parameter int unsigned LANE = 0,
    parameter int unsigned PW   = 5
) (
    input  logic            en_i,
    input  logic [PW-1:0]   phase_i,
    input  logic [N*DW-1:0] row_i,
    output logic [DW-1:0]   lane_o
);

    always_comb begin
        lane_o = '0;
        if (en_i) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (phase_i == PW'(LANE + k)) begin
                    lane_o = row_i[k*DW +: DW];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Loads N beats of A columns / B rows, then feeds them diagonally skewed into
// a systolic array edge with clear, stream, drain and done sequencing.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned DW           = DW_DEF,
    parameter int unsigned N            = N_DEF,
    parameter int unsigned DRAIN_CYCLES = N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a_col_in,
    input  logic [N*DW-1:0] b_row_in,
    output logic [N*DW-1:0] a_west,
    output logic [N*DW-1:0] b_north,
    output logic            arr_en,
    output logic            arr_clr,
    output logic            busy,
    output logic            done
);

    localparam int unsigned PW = $clog2(2*N - 1 + DRAIN_CYCLES) + 1;
    localparam int unsigned BW = cnt_w(N);

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic            accept;

    // a_row_q[i] holds row i of A; b_col_q[j] holds column j of B.
    logic [N*DW-1:0] a_row_q [N];
    logic [N*DW-1:0] b_col_q [N];

    logic [N*DW-1:0] a_west_q, a_west_d;
    logic [N*DW-1:0] b_north_q, b_north_d;
    logic            arr_en_q, arr_en_d;
    logic            arr_clr_q, arr_clr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            stream_d;

    assign in_ready = rst & (state_q == ST_IDLE);
    assign accept   = in_ready & in_valid;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (beat_cnt_q == BW'(N - 1)) begin
                        beat_cnt_d = '0;
                        state_d    = ST_CLEAR;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            ST_CLEAR:  state_d = ST_STREAM;
            ST_STREAM: begin
                if (phase_q == PW'(2*N - 2)) begin
                    state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (phase_q == PW'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        phase_d = '0;
        if ((state_d == state_q) && ((state_q == ST_STREAM) || (state_q == ST_DRAIN))) begin
            phase_d = phase_q + 1'b1;
        end
        stream_d  = (state_d == ST_STREAM);
        arr_en_d  = (state_d == ST_STREAM) || (state_d == ST_DRAIN);
        arr_clr_d = (state_d == ST_CLEAR);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        skew_select #(
            .DW   (DW),
            .N    (N),
            .LANE (g),
            .PW   (PW)
        ) u_skew_a (
            .en_i    (stream_d),
            .phase_i (phase_d),
            .row_i   (a_row_q[g]),
            .lane_o  (a_west_d[g*DW +: DW])
        );

        skew_select #(
            .DW   (DW),
            .N    (N),
            .LANE (g),
            .PW   (PW)
        ) u_skew_b (
            .en_i    (stream_d),
            .phase_i (phase_d),
            .row_i   (b_col_q[g]),
            .lane_o  (b_north_d[g*DW +: DW])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            phase_q    <= '0;
            a_west_q   <= '0;
            b_north_q  <= '0;
            arr_en_q   <= 1'b0;
            arr_clr_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            phase_q    <= phase_d;
            a_west_q   <= a_west_d;
            b_north_q  <= b_north_d;
            arr_en_q   <= arr_en_d;
            arr_clr_q  <= arr_clr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Operand buffers carry no reset; they are always rewritten before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned i = 0; i < N; i++) begin
                a_row_q[i][beat_cnt_q*DW +: DW] <= a_col_in[i*DW +: DW];
                b_col_q[i][beat_cnt_q*DW +: DW] <= b_row_in[i*DW +: DW];
            end
        end
    end

    assign a_west  = a_west_q;
    assign b_north = b_north_q;
    assign arr_en  = arr_en_q;
    assign arr_clr = arr_clr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
